uart_msg_ctrl: RTL and testbench

UART_MSG_CTRL -- requirements
Module: uart_msg_ctrl

---
 rtl/uart_msg_ctrl.sv | 148 ++++++++++++++
 tb/tb_uart_msg_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_msg_ctrl
// Brief    : Feeds a fixed message byte-by-byte into a UART transmitter,
//            optionally repeating it after an idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module uart_msg_ctrl #(
    parameter int                   MSG_LEN      = 12,
    parameter logic [8*MSG_LEN-1:0] MSG          = "Hello World\n",
    parameter int                   GAP_CYCLES   = 100_000_000,
    parameter int                   BUSY_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       repeat_en,
    input  logic       tx_busy,
    output logic [7:0] data_out,
    output logic       wr_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int c_CNT_MAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CYCLES - 1);
    // LOAD plus the WAIT_RISE cycles together make up the full BUSY_TIMEOUT window
    localparam logic [c_CNT_W-1:0] c_RISE_LAST = c_CNT_W'(BUSY_TIMEOUT - 2);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [7:0]         c_LAST_IDX  = 8'(MSG_LEN - 1);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_LOAD      = 3'd1;
    localparam logic [2:0] c_S_WAIT_RISE = 3'd2;
    localparam logic [2:0] c_S_WAIT_FALL = 3'd3;
    localparam logic [2:0] c_S_GAP       = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [7:0]         r_idx;
    logic [7:0]         w_idx_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_done;
    logic [7:0]         r_data;
    logic [7:0]         w_rom [0:255];

    // Full 256-entry table so the 8-bit index selects without width games
    generate
        for (genvar gi = 0; gi < 256; gi++) begin : g_rom
            if (gi < MSG_LEN) begin : g_byte
                assign w_rom[gi] = MSG[8*(MSG_LEN-1-gi) +: 8];
            end else begin : g_pad
                assign w_rom[gi] = 8'h00;
            end
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_done      = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (start && !tx_busy) begin
                    w_state_nxt = c_S_LOAD;
                    w_idx_nxt   = 8'd0;
                    w_err_nxt   = 1'b0;
                end
            end
            c_S_LOAD: begin
                w_state_nxt = c_S_WAIT_RISE;
                w_cnt_nxt   = '0;
            end
            c_S_WAIT_RISE: begin
                if (tx_busy) begin
                    w_state_nxt = c_S_WAIT_FALL;
                end else if (r_cnt == c_RISE_LAST) begin
                    w_state_nxt = c_S_IDLE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_S_WAIT_FALL: begin
                if (!tx_busy) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_done      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = repeat_en ? c_S_GAP : c_S_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + 8'd1;
                        w_state_nxt = c_S_LOAD;
                    end
                end
            end
            c_S_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    if (repeat_en) begin
                        w_state_nxt = c_S_LOAD;
                        w_idx_nxt   = 8'd0;
                    end else begin
                        w_state_nxt = c_S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
            r_idx   <= 8'd0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            // Byte is captured on entry so it is already valid during the LOAD strobe
            if (w_state_nxt == c_S_LOAD) begin
                r_data <= w_rom[w_idx_nxt];
            end
        end
    end

    assign data_out = r_data;
    assign wr_en    = (r_state == c_S_LOAD);
    assign busy     = (r_state != c_S_IDLE);
    assign done     = w_done;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_msg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_msg_ctrl
// Brief    : Directed self-checking bench for uart_msg_ctrl with a UART model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_msg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       repeat_en = 1'b0;
    logic       tx_busy;
    logic [7:0] data_out;
    logic       wr_en, busy, done, err;

    logic       start1 = 1'b0;
    logic       tx_busy1;
    logic [7:0] data_out1;
    logic       wr_en1, busy1, done1, err1;

    logic       mute = 1'b0;
    logic       force_busy = 1'b0;
    logic       m_pend, m_busy;
    int         m_cnt;
    logic       m1_pend, m1_busy;
    int         m1_cnt;

    int         n_tests = 0;
    int         n_fail = 0;

    logic [7:0] got [16];
    int         wr_cyc [16];
    int         n_wr, n_done, done_cyc, err_cyc, idle_cyc, wr_busy_bad;
    logic       busy_after_done, err_at0;

    always #5 clk = ~clk;

    assign tx_busy  = m_busy | force_busy;
    assign tx_busy1 = m1_busy;

    uart_msg_ctrl #(
        .MSG_LEN(3), .MSG("ABC"), .GAP_CYCLES(5), .BUSY_TIMEOUT(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .repeat_en(repeat_en),
        .tx_busy(tx_busy), .data_out(data_out), .wr_en(wr_en),
        .busy(busy), .done(done), .err(err)
    );

    uart_msg_ctrl #(
        .MSG_LEN(1), .MSG("Z"), .GAP_CYCLES(5), .BUSY_TIMEOUT(4)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .repeat_en(1'b0),
        .tx_busy(tx_busy1), .data_out(data_out1), .wr_en(wr_en1),
        .busy(busy1), .done(done1), .err(err1)
    );

    // UART model: busy rises 1 clk after a write strobe and stays high 10 clk
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0; m_busy <= 1'b0; m_cnt <= 0;
        end else begin
            m_pend <= wr_en && !mute;
            if (m_pend) begin
                m_busy <= 1'b1; m_cnt <= 10;
            end else if (m_busy) begin
                if (m_cnt == 1) m_busy <= 1'b0;
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_pend <= 1'b0; m1_busy <= 1'b0; m1_cnt <= 0;
        end else begin
            m1_pend <= wr_en1;
            if (m1_pend) begin
                m1_busy <= 1'b1; m1_cnt <= 10;
            end else if (m1_busy) begin
                if (m1_cnt == 1) m1_busy <= 1'b0;
                m1_cnt <= m1_cnt - 1;
            end
        end
    end

    // Pulses start, then records activity for ncyc cycles (cycle 0 = first cycle after the pulse)
    task automatic pulse_watch(input int ncyc, input int drop_cyc, input int xs_a, input int xs_b);
        n_wr = 0; n_done = 0; done_cyc = -1; err_cyc = -1; idle_cyc = -1;
        wr_busy_bad = 0; busy_after_done = 1'bx; err_at0 = 1'bx;
        start = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 0) err_at0 = err;
            if (wr_en) begin
                if (n_wr < 16) begin got[n_wr] = data_out; wr_cyc[n_wr] = c; end
                n_wr++;
                if (tx_busy) wr_busy_bad++;
            end
            if (done_cyc >= 0 && done_cyc == c - 1) busy_after_done = busy;
            if (done) begin n_done++; done_cyc = c; end
            if (err && err_cyc < 0) err_cyc = c;
            if (!busy && idle_cyc < 0) idle_cyc = c;
            if (c == drop_cyc) repeat_en = 1'b0;
            if (c == xs_a || c == xs_b) start = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data_out); end
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_repeat_alone();
        int wr_seen, busy_seen;
        wr_seen = 0; busy_seen = 0;
        repeat_en = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (wr_en) wr_seen++;
            if (busy) busy_seen++;
        end
        repeat_en = 1'b0;
        n_tests++; if (wr_seen !== 0) begin n_fail++; $display("FAIL repeat_alone_wr got=%0d exp=0", wr_seen); end
        n_tests++; if (busy_seen !== 0) begin n_fail++; $display("FAIL repeat_alone_busy got=%0d exp=0", busy_seen); end
    endtask

    task automatic test_basic_msg();
        pulse_watch(60, -1, -1, -1);
        n_tests++; if (n_wr !== 3) begin n_fail++; $display("FAIL basic_wr_count got=%0d exp=3", n_wr); end
        n_tests++; if (wr_cyc[0] !== 0) begin n_fail++; $display("FAIL basic_latency got=%0d exp=0", wr_cyc[0]); end
        n_tests++; if (got[0] !== 8'h41) begin n_fail++; $display("FAIL basic_byte0 got=%h exp=41", got[0]); end
        n_tests++; if (got[1] !== 8'h42) begin n_fail++; $display("FAIL basic_byte1 got=%h exp=42", got[1]); end
        n_tests++; if (got[2] !== 8'h43) begin n_fail++; $display("FAIL basic_byte2 got=%h exp=43", got[2]); end
        n_tests++; if (wr_cyc[1] !== 13) begin n_fail++; $display("FAIL basic_wr1_cycle got=%0d exp=13", wr_cyc[1]); end
        n_tests++; if (wr_cyc[2] !== 26) begin n_fail++; $display("FAIL basic_wr2_cycle got=%0d exp=26", wr_cyc[2]); end
        n_tests++; if (wr_busy_bad !== 0) begin n_fail++; $display("FAIL basic_wr_while_busy got=%0d exp=0", wr_busy_bad); end
        n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
        n_tests++; if (done_cyc !== 38) begin n_fail++; $display("FAIL basic_done_cycle got=%0d exp=38", done_cyc); end
        n_tests++; if (busy_after_done !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after_done got=%b exp=0", busy_after_done); end
        n_tests++; if (data_out !== 8'h43) begin n_fail++; $display("FAIL basic_data_hold got=%h exp=43", data_out); end
    endtask

    task automatic test_timeout();
        mute = 1'b1;
        pulse_watch(20, -1, -1, -1);
        mute = 1'b0;
        n_tests++; if (n_wr !== 1) begin n_fail++; $display("FAIL timeout_wr_count got=%0d exp=1", n_wr); end
        n_tests++; if (got[0] !== 8'h41) begin n_fail++; $display("FAIL timeout_byte got=%h exp=41", got[0]); end
        n_tests++; if (err_cyc !== 4) begin n_fail++; $display("FAIL timeout_err_cycle got=%0d exp=4", err_cyc); end
        n_tests++; if (idle_cyc !== 4) begin n_fail++; $display("FAIL timeout_idle_cycle got=%0d exp=4", idle_cyc); end
        n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL timeout_done got=%0d exp=0", n_done); end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky got=%b exp=1", err); end
        pulse_watch(60, -1, -1, -1);
        n_tests++; if (err_at0 !== 1'b0) begin n_fail++; $display("FAIL timeout_err_clear got=%b exp=0", err_at0); end
        n_tests++; if (n_wr !== 3) begin n_fail++; $display("FAIL timeout_resend_wr got=%0d exp=3", n_wr); end
    endtask

    task automatic test_repeat();
        repeat_en = 1'b1;
        pulse_watch(150, 50, -1, -1);
        n_tests++; if (n_wr !== 6) begin n_fail++; $display("FAIL repeat_wr_count got=%0d exp=6", n_wr); end
        n_tests++; if (wr_cyc[3] !== 44) begin n_fail++; $display("FAIL repeat_gap_len got=%0d exp=44", wr_cyc[3]); end
        n_tests++; if (got[3] !== 8'h41) begin n_fail++; $display("FAIL repeat_first_byte got=%h exp=41", got[3]); end
        n_tests++; if (got[5] !== 8'h43) begin n_fail++; $display("FAIL repeat_last_byte got=%h exp=43", got[5]); end
        n_tests++; if (n_done !== 2) begin n_fail++; $display("FAIL repeat_done_count got=%0d exp=2", n_done); end
        n_tests++; if (done_cyc !== 82) begin n_fail++; $display("FAIL repeat_done_cycle got=%0d exp=82", done_cyc); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL repeat_end_idle got=%b exp=0", busy); end
    endtask

    task automatic test_ignore_start();
        force_busy = 1'b1;
        pulse_watch(30, -1, -1, -1);
        force_busy = 1'b0;
        n_tests++; if (n_wr !== 0) begin n_fail++; $display("FAIL ignore_txbusy_wr got=%0d exp=0", n_wr); end
        n_tests++; if (idle_cyc !== 0) begin n_fail++; $display("FAIL ignore_txbusy_idle got=%0d exp=0", idle_cyc); end
        @(negedge clk);
        pulse_watch(80, -1, 12, 25);
        n_tests++; if (n_wr !== 3) begin n_fail++; $display("FAIL ignore_midmsg_wr got=%0d exp=3", n_wr); end
        n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL ignore_midmsg_done got=%0d exp=1", n_done); end
        n_tests++; if (got[1] !== 8'h42) begin n_fail++; $display("FAIL ignore_midmsg_byte1 got=%h exp=42", got[1]); end
    endtask

    task automatic test_reset_mid();
        int wr_seen;
        wr_seen = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        n_tests++; if (data_out !== 8'h42 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre data=%h busy=%b exp=42/1", data_out, busy); end
        rst_n = 1'b0;
        #1;
        n_tests++; if ({data_out, wr_en, busy, done, err} !== 12'h000) begin
            n_fail++; $display("FAIL rstmid_async data=%h wr=%b busy=%b done=%b err=%b exp=all 0", data_out, wr_en, busy, done, err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (wr_en || busy) wr_seen++;
        end
        n_tests++; if (wr_seen !== 0) begin n_fail++; $display("FAIL rstmid_after_release got=%0d exp=0", wr_seen); end
        pulse_watch(60, -1, -1, -1);
        n_tests++; if (n_wr !== 3) begin n_fail++; $display("FAIL rstmid_restart_wr got=%0d exp=3", n_wr); end
    endtask

    task automatic test_single_byte();
        int n1, d1cyc, b1;
        n1 = 0; d1cyc = -1; b1 = -1;
        start1 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (wr_en1) begin
                n1++;
                if (c == 0 && data_out1 !== 8'h5A) begin
                    n_tests++; n_fail++; $display("FAIL single_byte_data got=%h exp=5A", data_out1);
                end
            end
            if (d1cyc >= 0 && c == d1cyc + 1) b1 = int'(busy1);
            if (done1) d1cyc = c;
        end
        n_tests++; if (n1 !== 1) begin n_fail++; $display("FAIL single_wr_count got=%0d exp=1", n1); end
        n_tests++; if (d1cyc !== 12) begin n_fail++; $display("FAIL single_done_cycle got=%0d exp=12", d1cyc); end
        n_tests++; if (b1 !== 0) begin n_fail++; $display("FAIL single_busy_after got=%0d exp=0", b1); end
        n_tests++; if (data_out1 !== 8'h5A) begin n_fail++; $display("FAIL single_data_hold got=%h exp=5A", data_out1); end
    endtask

    initial begin
        test_reset();
        test_repeat_alone();
        test_basic_msg();
        test_timeout();
        test_repeat();
        test_ignore_start();
        test_reset_mid();
        test_single_byte();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired tests_run=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
